alu_share_arb: RTL and testbench

ALU_SHARE_ARB -- requirements
Module: alu_share_arb

---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu_arb_pick2.sv | 21 ++
 rtl/alu_share_arb.sv | 131 +++++++++++++
 tb/tb_alu_share_arb.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the two-requester ALU arbiter: opcodes, FSM states,
// and the illegal-opcode test.
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_LSL = 4'b0001;
    localparam logic [3:0] OP_LSR = 4'b0010;
    localparam logic [3:0] OP_AND = 4'b0011;
    localparam logic [3:0] OP_OR  = 4'b0100;
    localparam logic [3:0] OP_XOR = 4'b0101;
    localparam logic [3:0] OP_SLT = 4'b0110;
    localparam logic [3:0] OP_MOV = 4'b0111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Any opcode with bit 3 set lies outside the ADD..MOV set.
    function automatic logic is_illegal_op(input logic [3:0] op);
        return op[3];
    endfunction

endpackage

// File: rtl/alu_arb_pick2.sv
// Two-way arbitration pick: one-hot select, pointer names the preferred
// requester when both are asking.
module alu_arb_pick2 (
    input  logic       Req0,
    input  logic       Req1,
    input  logic       pointer,
    output logic [1:0] select
);

    always_comb begin
        select = '0;
        if (Req0 && Req1) begin
            select = pointer ? 2'b10 : 2'b01;
        end else if (Req0) begin
            select = 2'b01;
        end else if (Req1) begin
            select = 2'b10;
        end
    end

endmodule

// File: rtl/alu_share_arb.sv
// Shares one external ALU between two requesters (IDLE -> EXEC -> RESP).
// Define ALU_ARB_RR_EN for round-robin arbitration; default is fixed priority.
module alu_share_arb #(
    parameter int DW  = 8,
    parameter int OPW = 4
) (
    input  logic           CLK,
    input  logic           Reset_n,
    input  logic           Req0,
    input  logic           Req1,
    input  logic [DW-1:0]  A0,
    input  logic [DW-1:0]  A1,
    input  logic [DW-1:0]  B0,
    input  logic [DW-1:0]  B1,
    input  logic [OPW-1:0] Op0,
    input  logic [OPW-1:0] Op1,
    output logic           Gnt0,
    output logic           Gnt1,
    output logic [DW-1:0]  AluA,
    output logic [DW-1:0]  AluB,
    output logic [OPW-1:0] AluOp,
    input  logic [DW-1:0]  AluOut,
    input  logic           AluZero,
    output logic [DW-1:0]  Out,
    output logic           Zero,
    output logic           RespId,
    output logic           RespErr,
    output logic           RespValid,
    input  logic           RespReady,
    output logic           Busy
);

    import alu_pkg::*;

    state_t     state;
    state_t     state_nx;
    logic [1:0] sel;
    logic       ptr;
    logic       served;
    logic       grant;

    alu_arb_pick2 u_pick (
        .Req0    (Req0),
        .Req1    (Req1),
        .pointer (ptr),
        .select  (sel)
    );

    assign grant = (state == ST_IDLE) && (Req0 || Req1);
    assign Busy  = (state != ST_IDLE);

`ifdef ALU_ARB_RR_EN
    // After serving requester n, prefer the other one.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            ptr <= 1'b0;
        end else if (grant) begin
            ptr <= sel[0];
        end
    end
`else
    assign ptr = 1'b0;
`endif

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (Req0 || Req1) state_nx = ST_EXEC;
            ST_EXEC: state_nx = ST_RESP;
            ST_RESP: if (RespReady) state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            Gnt0      <= 1'b0;
            Gnt1      <= 1'b0;
            served    <= 1'b0;
            AluA      <= '0;
            AluB      <= '0;
            AluOp     <= '0;
            Out       <= '0;
            Zero      <= 1'b0;
            RespId    <= 1'b0;
            RespErr   <= 1'b0;
            RespValid <= 1'b0;
        end else begin
            Gnt0 <= 1'b0;
            Gnt1 <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (grant) begin
                        Gnt0   <= sel[0];
                        Gnt1   <= sel[1];
                        served <= sel[1];
                        AluA   <= sel[1] ? A1  : A0;
                        AluB   <= sel[1] ? B1  : B0;
                        AluOp  <= sel[1] ? Op1 : Op0;
                    end
                end
                ST_EXEC: begin
                    RespValid <= 1'b1;
                    RespId    <= served;
                    if (is_illegal_op(AluOp[3:0])) begin
                        Out     <= '0;
                        Zero    <= 1'b0;
                        RespErr <= 1'b1;
                    end else begin
                        Out     <= AluOut;
                        Zero    <= AluZero;
                        RespErr <= 1'b0;
                    end
                end
                ST_RESP: begin
                    if (RespReady) RespValid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed self-checking bench for alu_share_arb with a behavioural ALU.
// Expected grant order follows ALU_ARB_RR_EN when it is defined.
module tb_alu_share_arb;

    localparam int DW  = 8;
    localparam int OPW = 4;

    logic           CLK = 1'b0;
    logic           Reset_n;
    logic           Req0, Req1;
    logic [DW-1:0]  A0, A1, B0, B1;
    logic [OPW-1:0] Op0, Op1;
    logic           Gnt0, Gnt1;
    logic [DW-1:0]  AluA, AluB;
    logic [OPW-1:0] AluOp;
    logic [DW-1:0]  AluOut;
    logic           AluZero;
    logic [DW-1:0]  Out;
    logic           Zero, RespId, RespErr, RespValid, RespReady, Busy;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    alu_share_arb #(.DW(DW), .OPW(OPW)) dut (
        .CLK(CLK), .Reset_n(Reset_n),
        .Req0(Req0), .Req1(Req1),
        .A0(A0), .A1(A1), .B0(B0), .B1(B1),
        .Op0(Op0), .Op1(Op1),
        .Gnt0(Gnt0), .Gnt1(Gnt1),
        .AluA(AluA), .AluB(AluB), .AluOp(AluOp),
        .AluOut(AluOut), .AluZero(AluZero),
        .Out(Out), .Zero(Zero), .RespId(RespId), .RespErr(RespErr),
        .RespValid(RespValid), .RespReady(RespReady), .Busy(Busy)
    );

    // External ALU; SLT reports its comparison result on AluZero.
    always_comb begin
        AluZero = 1'b0;
        case (AluOp)
            4'd0: AluOut = AluA + AluB;
            4'd1: AluOut = AluA << AluB[2:0];
            4'd2: AluOut = AluA >> AluB[2:0];
            4'd3: AluOut = AluA & AluB;
            4'd4: AluOut = AluA | AluB;
            4'd5: AluOut = AluA ^ AluB;
            4'd6: AluOut = (AluA < AluB) ? 8'd1 : 8'd0;
            4'd7: AluOut = AluB;
            default: AluOut = 8'hA5;
        endcase
        if (AluOp == 4'd6) AluZero = (AluA < AluB);
        else if (AluOp[3]) AluZero = 1'b1;
        else AluZero = (AluOut == 8'd0);
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        Req0 = 0; Req1 = 0;
        A0 = '0; A1 = '0; B0 = '0; B1 = '0; Op0 = '0; Op1 = '0;
        RespReady = 1;
    endtask

    task automatic test_reset();
        idle_inputs();
        Reset_n = 0;
        #12;
        checks++;
        if ({Gnt0, Gnt1, RespValid, Out, Zero, RespId, RespErr, AluA, AluB, AluOp, Busy} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got Gnt=%b%b RV=%b Out=%h Z=%b Id=%b Err=%b A=%h B=%h Op=%h Busy=%b, expected all zero",
                     Gnt1, Gnt0, RespValid, Out, Zero, RespId, RespErr, AluA, AluB, AluOp, Busy);
        end
        @(negedge CLK);
        Reset_n = 1;
        tick();
    endtask

    task automatic test_basic_add();
        Req0 = 1; A0 = 8'h01; B0 = 8'h01; Op0 = 4'b0000; RespReady = 1;
        tick();
        checks++;
        if (Gnt0 !== 1'b1 || Gnt1 !== 1'b0 || Busy !== 1'b1 || AluA !== 8'h01 || AluB !== 8'h01) begin
            errors++;
            $display("FAIL add_grant: got Gnt0=%b Gnt1=%b Busy=%b AluA=%h AluB=%h, expected 1 0 1 01 01",
                     Gnt0, Gnt1, Busy, AluA, AluB);
        end
        Req0 = 0;
        tick();
        checks++;
        if (Gnt0 !== 1'b0 || RespValid !== 1'b1 || Out !== 8'h02 || RespId !== 1'b0 || RespErr !== 1'b0 || Zero !== 1'b0) begin
            errors++;
            $display("FAIL add_resp: got Gnt0=%b RV=%b Out=%h Id=%b Err=%b Z=%b, expected 0 1 02 0 0 0",
                     Gnt0, RespValid, Out, RespId, RespErr, Zero);
        end
        tick();
        checks++;
        if (RespValid !== 1'b0 || Busy !== 1'b0) begin
            errors++;
            $display("FAIL add_release: got RV=%b Busy=%b, expected 0 0", RespValid, Busy);
        end
    endtask

    task automatic test_arbitration();
        int     n;
        logic   got [3];
        logic   exp [3];
`ifdef ALU_ARB_RR_EN
        exp[0] = 0; exp[1] = 1; exp[2] = 0;
`else
        exp[0] = 0; exp[1] = 0; exp[2] = 0;
`endif
        n = 0;
        idle_inputs();
        Reset_n = 0;
        #3;
        Req0 = 1; Req1 = 1;
        A0 = 8'h10; B0 = 8'h01; A1 = 8'h20; B1 = 8'h02;
        @(negedge CLK);
        Reset_n = 1;
        for (int c = 0; c < 30 && n < 3; c++) begin
            tick();
            checks++;
            if (Gnt0 && Gnt1) begin
                errors++;
                $display("FAIL arb_exclusive: got Gnt0=1 Gnt1=1, expected at most one");
            end
            if (Gnt0 || Gnt1) begin
                got[n] = Gnt1;
                n++;
            end
        end
        Req0 = 0; Req1 = 0;
        checks++;
        if (n != 3) begin
            errors++;
            $display("FAIL arb_count: got %0d grants, expected 3", n);
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (got[i] !== exp[i]) begin
                    errors++;
                    $display("FAIL arb_order_%0d: got requester %0d, expected %0d", i, got[i], exp[i]);
                end
            end
        end
        for (int c = 0; c < 6; c++) tick();
    endtask

    task automatic test_slt();
        logic [7:0] a_v [2];
        logic [7:0] b_v [2];
        logic       z_v [2];
        a_v[0] = 8'h01; b_v[0] = 8'h02; z_v[0] = 1'b1;
        a_v[1] = 8'h02; b_v[1] = 8'h01; z_v[1] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            Req1 = 1; A1 = a_v[i]; B1 = b_v[i]; Op1 = 4'b0110; RespReady = 1;
            tick();
            checks++;
            if (Gnt1 !== 1'b1 || Gnt0 !== 1'b0 || AluOp !== 4'b0110) begin
                errors++;
                $display("FAIL slt_grant_%0d: got Gnt1=%b Gnt0=%b AluOp=%b, expected 1 0 0110", i, Gnt1, Gnt0, AluOp);
            end
            Req1 = 0;
            tick();
            checks++;
            if (RespValid !== 1'b1 || Zero !== z_v[i] || RespId !== 1'b1 || RespErr !== 1'b0) begin
                errors++;
                $display("FAIL slt_resp_%0d: got RV=%b Zero=%b Id=%b Err=%b, expected 1 %b 1 0",
                         i, RespValid, Zero, RespId, RespErr, z_v[i]);
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        Req0 = 1; A0 = 8'h03; B0 = 8'h04; Op0 = 4'b0000; RespReady = 0;
        tick();
        tick();
        checks++;
        if (RespValid !== 1'b1 || Out !== 8'h07) begin
            errors++;
            $display("FAIL bp_first: got RV=%b Out=%h, expected 1 07", RespValid, Out);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (RespValid !== 1'b1 || Out !== 8'h07 || Zero !== 1'b0 || Gnt0 !== 1'b0 || Gnt1 !== 1'b0 || Busy !== 1'b1
                || AluA !== 8'h03 || AluB !== 8'h04) begin
                errors++;
                $display("FAIL bp_hold_%0d: got RV=%b Out=%h Z=%b Gnt=%b%b Busy=%b AluA=%h AluB=%h, expected 1 07 0 00 1 03 04",
                         c, RespValid, Out, Zero, Gnt1, Gnt0, Busy, AluA, AluB);
            end
        end
        RespReady = 1; Req0 = 0;
        tick();
        checks++;
        if (RespValid !== 1'b0 || Busy !== 1'b0 || Gnt0 !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: got RV=%b Busy=%b Gnt0=%b, expected 0 0 0", RespValid, Busy, Gnt0);
        end
    endtask

    task automatic test_reset_mid_exec();
        Req0 = 1; A0 = 8'hFF; B0 = 8'h02; Op0 = 4'b0000; RespReady = 1;
        tick();
        Req0 = 0;
        checks++;
        if (Gnt0 !== 1'b1 || Busy !== 1'b1) begin
            errors++;
            $display("FAIL midrst_pre: got Gnt0=%b Busy=%b, expected 1 1", Gnt0, Busy);
        end
        #2;
        Reset_n = 0;
        #1;
        checks++;
        if ({Gnt0, Gnt1, RespValid, Out, Zero, RespId, RespErr, AluA, AluB, AluOp, Busy} !== '0) begin
            errors++;
            $display("FAIL midrst_async: got Gnt=%b%b RV=%b Out=%h Z=%b Id=%b Err=%b A=%h B=%h Op=%h Busy=%b, expected all zero",
                     Gnt1, Gnt0, RespValid, Out, Zero, RespId, RespErr, AluA, AluB, AluOp, Busy);
        end
        tick();
        @(negedge CLK);
        Reset_n = 1;
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++;
            if (RespValid !== 1'b0 || Busy !== 1'b0) begin
                errors++;
                $display("FAIL midrst_after_%0d: got RV=%b Busy=%b, expected 0 0", c, RespValid, Busy);
            end
        end
    endtask

    task automatic test_illegal_op();
        Req0 = 1; A0 = 8'h05; B0 = 8'h05; Op0 = 4'b1000; RespReady = 1;
        tick();
        Req0 = 0;
        tick();
        checks++;
        if (RespValid !== 1'b1 || Out !== 8'h00 || Zero !== 1'b0 || RespErr !== 1'b1 || AluOp !== 4'b1000) begin
            errors++;
            $display("FAIL illegal_resp: got RV=%b Out=%h Z=%b Err=%b AluOp=%b, expected 1 00 0 1 1000",
                     RespValid, Out, Zero, RespErr, AluOp);
        end
        tick();
        Req0 = 1; A0 = 8'h0C; B0 = 8'h0A; Op0 = 4'b0101;
        tick();
        Req0 = 0;
        tick();
        checks++;
        if (RespValid !== 1'b1 || Out !== 8'h06 || RespErr !== 1'b0) begin
            errors++;
            $display("FAIL xor_after_illegal: got RV=%b Out=%h Err=%b, expected 1 06 0", RespValid, Out, RespErr);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic_add();
        test_arbitration();
        test_slt();
        test_backpressure();
        test_reset_mid_exec();
        test_illegal_op();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
